bilin_issue_ctrl: RTL and testbench

//  Sequencer for the fixed-latency bilinear interpolation datapath. On start, walks the output

---
 rtl/bilin_pkg.sv | 25 ++
 rtl/bilin_issue_ctrl_vld_pipe.sv | 34 +++
 rtl/bilin_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bilin_issue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bilin_pkg.sv
// Shared types and helpers for the bilinear issue controller.
// Holds the FSM state encoding, default widths and Q-format split helpers.
package bilin_pkg;

    localparam int CW_DEF   = 12;
    localparam int FRAC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Integer part of a Q value carried in 32 bits with `frac` fraction bits.
    function automatic logic [31:0] q_int(input logic [31:0] q, input int frac);
        return q >> frac;
    endfunction

    // Fraction part of a Q value carried in 32 bits with `frac` fraction bits.
    function automatic logic [31:0] q_frac(input logic [31:0] q, input int frac);
        return q & ((32'd1 << frac) - 32'd1);
    endfunction

endpackage

// File: rtl/bilin_issue_ctrl_vld_pipe.sv
// Resettable delay line for {last, valid} matching the datapath latency.
// any_busy looks one clk ahead so the drain can finish as the tail leaves.
module bilin_vld_pipe #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_busy
);

    logic [DEPTH-1:0][WIDTH-1:0] stg_q;
    logic [DEPTH-1:0][WIDTH-1:0] stg_d;

    // Shift one stage per clk; stage 0 takes the new entry.
    always_comb begin
        stg_d = {stg_q[DEPTH-2:0], din};
    end

    // Stage registers, cleared on reset so in-flight entries vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign dout     = stg_q[DEPTH-1];
    assign any_busy = |stg_q[DEPTH-2:0];

endmodule

// File: rtl/bilin_issue_ctrl.sv
// Raster-order coordinate sequencer for the bilinear datapath.
// Issues one source coordinate per clk while downstream credits remain.
module bilin_issue_ctrl
    import bilin_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int LAT     = 4,
    parameter int CREDITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CW-1:0]      out_w,
    input  logic [CW-1:0]      out_h,
    input  logic [CW+FRAC-1:0] step_x,
    input  logic [CW+FRAC-1:0] step_y,
    input  logic               credit_ret,
    output logic               issue,
    output logic [CW-1:0]      src_x,
    output logic [CW-1:0]      src_y,
    output logic [FRAC-1:0]    frac_x,
    output logic [FRAC-1:0]    frac_y,
    output logic               res_valid,
    output logic               res_last,
    output logic               busy,
    output logic               done
);

    localparam int QW  = CW + FRAC;
    localparam int CRW = $clog2(CREDITS + 1);

    localparam logic [CW-1:0]  ONE_W   = 1;
    localparam logic [CRW-1:0] CRD_ONE = 1;
    localparam logic [CRW-1:0] CRD_MAX = CRW'(CREDITS);

    state_e         state_q, state_d;
    logic [CW-1:0]  w_q, w_d, h_q, h_d;
    logic [QW-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [QW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [QW-1:0]  hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic [CW-1:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [CRW-1:0] crd_q, crd_d;
    logic           last;
    logic           crd_up;
    logic           pend;
    logic [1:0]     vld_out;
    logic [QW-1:0]  sel_x, sel_y;

    // FSM next state, raster walk, accumulators and status strobes.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        hold_x_d = hold_x_q;
        hold_y_d = hold_y_q;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        issue    = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    w_d     = out_w;
                    h_d     = out_h;
                    sx_d    = step_x;
                    sy_d    = step_y;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    if (out_w == '0 || out_h == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (crd_q != '0) begin
                    issue    = 1'b1;
                    hold_x_d = acc_x_q;
                    hold_y_d = acc_y_q;
                    if (x_cnt_q == w_q - ONE_W) begin
                        x_cnt_d = '0;
                        acc_x_d = '0;
                        y_cnt_d = y_cnt_q + ONE_W;
                        acc_y_d = acc_y_q + sy_q;
                        if (y_cnt_q == h_q - ONE_W) begin
                            last    = 1'b1;
                            state_d = DRAIN;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + ONE_W;
                        acc_x_d = acc_x_q + sx_q;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pend) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counter: issue consumes, credit_ret returns, saturating at full.
    always_comb begin
        crd_up = credit_ret && (issue || crd_q != CRD_MAX);
        crd_d  = crd_q;
        if (issue && !crd_up) begin
            crd_d = crd_q - CRD_ONE;
        end else if (!issue && crd_up) begin
            crd_d = crd_q + CRD_ONE;
        end
    end

    // Coordinate outputs: live on issue, otherwise hold the last issued one.
    always_comb begin
        sel_x  = issue ? acc_x_q : hold_x_q;
        sel_y  = issue ? acc_y_q : hold_y_q;
        src_x  = CW'(q_int(32'(sel_x), FRAC));
        src_y  = CW'(q_int(32'(sel_y), FRAC));
        frac_x = FRAC'(q_frac(32'(sel_x), FRAC));
        frac_y = FRAC'(q_frac(32'(sel_y), FRAC));
    end

    // State, config, walk and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            hold_x_q <= '0;
            hold_y_q <= '0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            crd_q    <= CRD_MAX;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            h_q      <= h_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            hold_x_q <= hold_x_d;
            hold_y_q <= hold_y_d;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            crd_q    <= crd_d;
        end
    end

    bilin_vld_pipe #(
        .WIDTH (2),
        .DEPTH (LAT)
    ) u_vld_pipe (
        .clk      (clk),
        .rst      (rst),
        .din      ({issue & last, issue}),
        .dout     (vld_out),
        .any_busy (pend)
    );

    assign res_valid = vld_out[0];
    assign res_last  = vld_out[1];

endmodule

// File: tb/tb_bilin_issue_ctrl.sv
// Scoreboard bench for bilin_issue_ctrl.
// Expected coordinates are queued at start and matched against each issue.
module tb_bilin_issue_ctrl;

    localparam int CW      = 12;
    localparam int FRAC    = 8;
    localparam int QW      = CW + FRAC;
    localparam int LAT     = 4;

    typedef struct {
        int   cyc;
        logic last;
    } res_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   out_w;
    logic [CW-1:0]   out_h;
    logic [QW-1:0]   step_x;
    logic [QW-1:0]   step_y;
    logic            credit_ret;
    logic            issue;
    logic [CW-1:0]   src_x;
    logic [CW-1:0]   src_y;
    logic [FRAC-1:0] frac_x;
    logic [FRAC-1:0] frac_y;
    logic            res_valid;
    logic            res_last;
    logic            busy;
    logic            done;

    logic [2*QW:0] exp_q[$];
    res_t          res_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_issue = 0;
    int n_res = 0;
    int n_last = 0;
    int n_done = 0;
    int done_cyc = 0;
    int last_iss = 0;
    int busy_seen = 0;

    bilin_issue_ctrl #(
        .CW      (CW),
        .FRAC    (FRAC),
        .LAT     (LAT),
        .CREDITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_w      (out_w),
        .out_h      (out_h),
        .step_x     (step_x),
        .step_y     (step_y),
        .credit_ret (credit_ret),
        .issue      (issue),
        .src_x      (src_x),
        .src_y      (src_y),
        .frac_x     (frac_x),
        .frac_y     (frac_y),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int w, input int h,
                               input logic [QW-1:0] sx, input logic [QW-1:0] sy);
        logic [QW-1:0] ax;
        logic [QW-1:0] ay;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                ay = QW'(y * sy);
                ax = QW'(x * sx);
                exp_q.push_back({(x == w - 1 && y == h - 1), ay, ax});
            end
        end
        out_w  = CW'(w);
        out_h  = CW'(h);
        step_x = sx;
        step_y = sy;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = n_done;
        int k = 0;
        while (n_done == d0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, n_done - d0, 1);
    endtask

    task automatic wait_issues(input int base, input int n, input string tag);
        int k = 0;
        while (n_issue - base < n && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, n_issue - base, n);
    endtask

    // Monitor: match issues against queued coordinates and results against issue times.
    always @(negedge clk) begin
        logic [2*QW:0] e;
        res_t          r;
        if (!rst) begin
            if (busy) busy_seen++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (issue) begin
                n_issue++;
                last_iss = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_issue", issue, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("coord", {src_y, frac_y, src_x, frac_x}, e[2*QW-1:0]);
                    r.cyc  = cyc + LAT;
                    r.last = e[2*QW];
                    res_q.push_back(r);
                end
            end
            if (res_valid) begin
                n_res++;
                if (res_last) n_last++;
                if (res_q.size() == 0) begin
                    check("extra_res", res_valid, 0);
                end else begin
                    r = res_q.pop_front();
                    check("res_cyc", cyc, r.cyc);
                    check("res_last", res_last, r.last);
                end
            end else begin
                if (res_last) check("stray_last", res_last, 0);
                if (res_q.size() != 0 && res_q[0].cyc <= cyc) begin
                    r = res_q.pop_front();
                    check("res_missing", res_valid, 1);
                end
            end
        end
    end

    initial begin
        int s;
        int i0;
        int i1;
        int r0;
        int l0;
        int b0;
        rst        = 1'b1;
        start      = 1'b0;
        credit_ret = 1'b0;
        out_w      = '0;
        out_h      = '0;
        step_x     = '0;
        step_y     = '0;
        tick(3);
        check("rst_out", {issue, res_valid, res_last, busy, done,
                          src_x, src_y, frac_x, frac_y}, 0);
        rst = 1'b0;
        tick(1);

        // 4x2 frame at step 1.5, credits always returned
        credit_ret = 1'b1;
        i0 = n_issue;
        s  = cyc;
        start_frame(4, 2, 20'h00180, 20'h00180);
        wait_done(40, "t1_done");
        check("t1_count", n_issue - i0, 8);
        check("t1_last_cyc", last_iss, s + 8);
        check("t1_done_lat", done_cyc - last_iss, LAT + 1);
        credit_ret = 1'b0;
        tick(2);

        // credit starvation: 8 issues then stall, one issue per returned credit
        i0 = n_issue;
        start_frame(4, 4, 20'h00100, 20'h00040);
        tick(15);
        check("t2_stall", n_issue - i0, 8);
        check("t2_issue_low", issue, 0);
        for (int k = 0; k < 8; k++) begin
            credit_ret = 1'b1;
            tick(1);
            credit_ret = 1'b0;
            check("t2_iss_after_crd", issue, 1);
            tick(1);
            check("t2_iss_stop", issue, 0);
            tick(1);
        end
        wait_done(30, "t2_done");
        check("t2_count", n_issue - i0, 16);
        credit_ret = 1'b1;
        tick(10);
        credit_ret = 1'b0;

        // zero-width frame: immediate done, nothing issued
        s  = cyc;
        b0 = busy_seen;
        i0 = n_issue;
        r0 = n_res;
        start_frame(0, 5, 20'h00100, 20'h00100);
        wait_done(10, "t3_done");
        check("t3_done_cyc", done_cyc, s + 1);
        check("t3_busy", busy_seen - b0, 0);
        check("t3_issue", n_issue - i0, 0);
        tick(8);
        check("t3_res", n_res - r0, 0);

        // reset mid-run abandons the frame and restores credits
        i0 = n_issue;
        start_frame(4, 4, 20'h000C0, 20'h000A0);
        wait_issues(i0, 3, "t4_three");
        r0  = n_res;
        rst = 1'b1;
        #1;
        check("t4_rst_out", {issue, res_valid, res_last, busy, done,
                             src_x, src_y, frac_x, frac_y}, 0);
        exp_q.delete();
        res_q.delete();
        tick(2);
        rst = 1'b0;
        tick(LAT + 3);
        check("t4_no_res", n_res - r0, 0);
        i0 = n_issue;
        start_frame(2, 4, 20'h00200, 20'h00100);
        wait_done(30, "t4_done");
        check("t4_credits", n_issue - i0, 8);
        credit_ret = 1'b1;
        tick(10);
        credit_ret = 1'b0;

        // credits held at 1 with simultaneous return; start during run ignored
        i0 = n_issue;
        start_frame(8, 4, 20'hFFF80, 20'h001F0);
        wait_issues(i0, 7, "t5_seven");
        credit_ret = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("t5_cont", issue, 1);
            if (k == 5) begin
                out_w = 12'd1;
                out_h = 12'd1;
                start = 1'b1;
            end
            if (k == 6) start = 1'b0;
            tick(1);
        end
        credit_ret = 1'b0;
        i1 = n_issue;
        tick(5);
        check("t5_one_left", n_issue - i1, 1);
        credit_ret = 1'b1;
        wait_done(60, "t5_done");
        check("t5_count", n_issue - i0, 32);
        tick(10);
        credit_ret = 1'b0;

        // 3x1 frame: last flag only on third result
        r0 = n_res;
        l0 = n_last;
        start_frame(3, 1, 20'h00155, 20'h00100);
        wait_done(20, "t6_done");
        check("t6_res", n_res - r0, 3);
        check("t6_last", n_last - l0, 1);

        tick(2);
        check("sb_empty", exp_q.size() + res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
